pixel_array_ctrl: RTL and testbench

//  Parametrised frame sequencer for an R x C pixel sensor array.

---
 rtl/pixel_ctrl_pkg.sv | 28 ++
 rtl/pixel_ramp_gen.sv | 27 ++
 rtl/pixel_array_ctrl.sv | 159 +++++++++++++++
 tb/tb_pixel_array_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_ctrl_pkg.sv
// Shared types and cycle-count helpers for the pixel array frame sequencer.
package pixel_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_ROW_SEL,
    ST_ROW_OUT
  } pix_state_t;

  // Number of cycles the conversion ramp takes to sweep every code once.
  function automatic int unsigned ramp_len(input int unsigned data_w);
    return 32'd1 << data_w;
  endfunction

  // Cycles from the start cycle to the frame_done cycle with the consumer always ready.
  function automatic int unsigned frame_len(input int unsigned erase_cyc,
                                            input int unsigned exp_len,
                                            input int unsigned data_w,
                                            input int unsigned num_rows);
    int unsigned exp_eff;
    exp_eff = (exp_len == 0) ? 1 : exp_len;
    return erase_cyc + exp_eff + ramp_len(data_w) + 2 * num_rows;
  endfunction

endpackage

// File: rtl/pixel_ramp_gen.sv
// Ramp code generator: up-counter with synchronous clear, enable and a
// terminal-count flag raised on the all-ones code.
module pixel_ramp_gen #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [DATA_W-1:0] cnt,
  output logic              tc
);

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + DATA_W'(1);
  end

  assign tc = &cnt;

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for an R x C pixel array: erase, expose, ramp conversion,
// then row-by-row capture onto a valid/ready stream.
module pixel_array_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_ROWS  = 2,
  parameter int NUM_COLS  = 2,
  parameter int ERASE_CYC = 5,
  parameter int EXP_W     = 16,
  localparam int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       cont_mode,
  input  logic [EXP_W-1:0]           expose_len,
  output logic                       erase,
  output logic                       expose,
  output logic                       convert,
  output logic [DATA_W-1:0]          ramp_data,
  output logic                       ramp_oe,
  output logic [NUM_ROWS-1:0]        read_row,
  input  logic [NUM_COLS*DATA_W-1:0] pix_data,
  output logic [NUM_COLS*DATA_W-1:0] out_data,
  output logic [ROW_W-1:0]           out_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       frame_done
);

  // The phase timer must hold both the erase length and any exposure length.
  localparam int ERASE_W = $clog2(ERASE_CYC + 1);
  localparam int TMR_W   = (EXP_W > ERASE_W) ? EXP_W : ERASE_W;

  pix_state_t          state, next_state;
  logic [TMR_W-1:0]    timer;
  logic [EXP_W-1:0]    exp_lat;
  logic [ROW_W-1:0]    row;
  logic [NUM_ROWS-1:0] row_onehot;
  logic [DATA_W-1:0]   ramp_cnt;
  logic                ramp_tc;
  logic                timer_done;
  logic                last_row;
  logic                accept;
  logic                enter_erase;
  logic                enter_expose;

  assign timer_done   = (timer == '0);
  assign last_row     = (row == ROW_W'(NUM_ROWS - 1));
  assign accept       = (state == ST_ROW_OUT) && out_ready;
  assign row_onehot   = NUM_ROWS'(1) << row;
  assign enter_erase  = (next_state == ST_ERASE) && (state != ST_ERASE);
  assign enter_expose = (state == ST_ERASE) && timer_done;

  pixel_ramp_gen #(.DATA_W(DATA_W)) u_ramp (
    .clk   (clk),
    .reset (reset),
    .clr   (state != ST_CONVERT),
    .en    (state == ST_CONVERT),
    .cnt   (ramp_cnt),
    .tc    (ramp_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    erase      = 1'b0;
    expose     = 1'b0;
    convert    = 1'b0;
    ramp_oe    = 1'b0;
    ramp_data  = '0;
    read_row   = '0;
    out_valid  = 1'b0;
    frame_done = 1'b0;
    busy       = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (start) next_state = ST_ERASE;
      end
      ST_ERASE: begin
        erase = 1'b1;
        if (timer_done) next_state = ST_EXPOSE;
      end
      ST_EXPOSE: begin
        expose = 1'b1;
        if (timer_done) next_state = ST_CONVERT;
      end
      ST_CONVERT: begin
        convert   = 1'b1;
        ramp_oe   = 1'b1;
        ramp_data = ramp_cnt;
        if (ramp_tc) next_state = ST_ROW_SEL;
      end
      ST_ROW_SEL: begin
        read_row   = row_onehot;
        next_state = ST_ROW_OUT;
      end
      ST_ROW_OUT: begin
        read_row  = row_onehot;
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_row) begin
            frame_done = 1'b1;
            next_state = cont_mode ? ST_ERASE : ST_IDLE;
          end else begin
            next_state = ST_ROW_SEL;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Exposure is latched on every ERASE entry; a zero request still exposes once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer   <= '0;
      exp_lat <= '0;
      row     <= '0;
    end else begin
      if (enter_erase)
        exp_lat <= (expose_len == '0) ? EXP_W'(1) : expose_len;

      if (enter_erase)
        timer <= TMR_W'(ERASE_CYC - 1);
      else if (enter_expose)
        timer <= TMR_W'(exp_lat) - TMR_W'(1);
      else if (!timer_done)
        timer <= timer - TMR_W'(1);

      if (state == ST_CONVERT)
        row <= '0;
      else if (accept && !last_row)
        row <= row + ROW_W'(1);
    end
  end

  // The settle cycle lets the selected row drive the bus; capture at its end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      out_row  <= '0;
    end else if (state == ST_ROW_SEL) begin
      out_data <= pix_data;
      out_row  <= row;
    end
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Scoreboard bench for pixel_array_ctrl: a default 2x2x8 instance and a 4x3x4
// instance, each fed by a behavioural pixel model that latches ramp codes.
module tb_pixel_array_ctrl;
  import pixel_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          row;
    logic [15:0] data;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  // Default instance: 2 rows, 2 cols, 8-bit
  logic        start0 = 1'b0, cont0 = 1'b0, ordy0 = 1'b1;
  logic [15:0] explen0 = '0;
  logic        erase0, expose0, convert0, oe0, ov0, busy0, fd0;
  logic [7:0]  ramp0;
  logic [1:0]  rr0;
  logic [15:0] pix0, od0;
  logic [0:0]  orow0;

  pixel_array_ctrl dut0 (
    .clk(clk), .reset(reset), .start(start0), .cont_mode(cont0),
    .expose_len(explen0), .erase(erase0), .expose(expose0), .convert(convert0),
    .ramp_data(ramp0), .ramp_oe(oe0), .read_row(rr0), .pix_data(pix0),
    .out_data(od0), .out_row(orow0), .out_valid(ov0), .out_ready(ordy0),
    .busy(busy0), .frame_done(fd0)
  );

  // Large instance: 4 rows, 3 cols, 4-bit
  logic        start1 = 1'b0, cont1 = 1'b0, ordy1 = 1'b1;
  logic [15:0] explen1 = '0;
  logic        erase1, expose1, convert1, oe1, ov1, busy1, fd1;
  logic [3:0]  ramp1;
  logic [3:0]  rr1;
  logic [11:0] pix1, od1;
  logic [1:0]  orow1;

  pixel_array_ctrl #(.DATA_W(4), .NUM_ROWS(4), .NUM_COLS(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .cont_mode(cont1),
    .expose_len(explen1), .erase(erase1), .expose(expose1), .convert(convert1),
    .ramp_data(ramp1), .ramp_oe(oe1), .read_row(rr1), .pix_data(pix1),
    .out_data(od1), .out_row(orow1), .out_valid(ov1), .out_ready(ordy1),
    .busy(busy1), .frame_done(fd1)
  );

  // Pixel models: each pixel latches the ramp code equal to its target level.
  logic [7:0] tgt0 [2][2];
  logic [7:0] lat0 [2][2];
  logic [3:0] tgt1 [4][3];
  logic [3:0] lat1 [4][3];

  always @(posedge clk) begin
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        if (reset || erase0) lat0[r][c] <= '0;
        else if (oe0 && ramp0 == tgt0[r][c]) lat0[r][c] <= ramp0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (reset || erase1) lat1[r][c] <= '0;
        else if (oe1 && ramp1 == tgt1[r][c]) lat1[r][c] <= ramp1;
  end

  always_comb begin
    pix0 = '0;
    for (int r = 0; r < 2; r++)
      if (rr0[r]) pix0 = {lat0[r][1], lat0[r][0]};
  end

  always_comb begin
    pix1 = '0;
    for (int r = 0; r < 4; r++)
      if (rr1[r]) pix1 = {lat1[r][2], lat1[r][1], lat1[r][0]};
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Walks one frame of dut0 starting at its first ERASE cycle.
  task automatic walk0(input int e_eff, input int stall, input bit cont_next);
    int          s, n;
    exp_t        item;
    logic [15:0] hold_d;
    logic [0:0]  hold_r;
    logic [1:0]  hold_rr;
    s = int'(cyc) - 1;
    for (int r = 0; r < 2; r++)
      sb0.push_back('{row: r, data: {tgt0[r][1], tgt0[r][0]}});

    n = 0;
    while (erase0 === 1'b1 && n < 64) begin
      total++;
      if ({expose0, convert0, |rr0, ov0} !== 4'b0 || busy0 !== 1'b1) begin
        bad++;
        $display("FAIL erase_excl cyc=%0d got expose=%b convert=%b read_row=%b busy=%b want only erase",
                 cyc, expose0, convert0, rr0, busy0);
      end
      n++; tick();
    end
    total++;
    if (n !== 5) begin bad++; $display("FAIL erase_len got %0d want 5", n); end

    n = 0;
    while (expose0 === 1'b1 && n < 4096) begin
      total++;
      if ({erase0, convert0, |rr0} !== 3'b0) begin
        bad++;
        $display("FAIL expose_excl cyc=%0d got erase=%b convert=%b read_row=%b want 0", cyc, erase0, convert0, rr0);
      end
      n++; tick();
    end
    total++;
    if (n !== e_eff) begin bad++; $display("FAIL expose_len got %0d want %0d", n, e_eff); end

    n = 0;
    while (convert0 === 1'b1 && n < 1024) begin
      total++;
      if (ramp0 !== 8'(n) || oe0 !== 1'b1 || {erase0, expose0, |rr0} !== 3'b0) begin
        bad++;
        $display("FAIL ramp step=%0d got ramp=%0d oe=%b want ramp=%0d oe=1", n, ramp0, oe0, n);
      end
      n++; tick();
    end
    total++;
    if (n !== int'(ramp_len(8))) begin bad++; $display("FAIL convert_len got %0d want %0d", n, ramp_len(8)); end
    total++;
    if (ramp0 !== 8'd0 || oe0 !== 1'b0) begin
      bad++; $display("FAIL ramp_exit got ramp=%0d oe=%b want 0 0", ramp0, oe0);
    end

    for (int r = 0; r < 2; r++) begin
      total++;
      if (rr0 !== 2'(1 << r) || ov0 !== 1'b0 || convert0 !== 1'b0) begin
        bad++; $display("FAIL row_sel r=%0d got read_row=%b valid=%b want %b 0", r, rr0, ov0, 2'(1 << r));
      end
      tick();
      total++;
      if (ov0 !== 1'b1 || rr0 !== 2'(1 << r)) begin
        bad++; $display("FAIL row_out r=%0d got valid=%b read_row=%b want 1 %b", r, ov0, rr0, 2'(1 << r));
      end
      if (r == 0 && stall > 0) begin
        ordy0 = 1'b0;
        hold_d = od0; hold_r = orow0; hold_rr = rr0;
        for (int i = 0; i < stall; i++) begin
          tick();
          total++;
          if (od0 !== hold_d || orow0 !== hold_r || rr0 !== hold_rr || ov0 !== 1'b1 || fd0 !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold i=%0d got data=%h row=%0d read_row=%b valid=%b want %h %0d %b 1",
                     i, od0, orow0, rr0, ov0, hold_d, hold_r, hold_rr);
          end
        end
        ordy0 = 1'b1;
      end
      #1;
      total++;
      if (sb0.size() == 0) begin
        bad++; $display("FAIL sb0_empty got no expected row want one queued");
      end else begin
        item = sb0.pop_front();
        if (od0 !== item.data || orow0 !== 1'(item.row)) begin
          bad++;
          $display("FAIL row_data r=%0d got data=%h row=%0d want data=%h row=%0d", r, od0, orow0, item.data, item.row);
        end
      end
      total++;
      if (fd0 !== (r == 1)) begin bad++; $display("FAIL frame_done r=%0d got %b want %b", r, fd0, (r == 1)); end
      if (r == 1) begin
        total++;
        if (int'(cyc) !== s + int'(frame_len(5, e_eff, 8, 2)) + stall) begin
          bad++;
          $display("FAIL latency got %0d want %0d", int'(cyc) - s, int'(frame_len(5, e_eff, 8, 2)) + stall);
        end
      end
      tick();
    end

    total++;
    if (cont_next) begin
      if (erase0 !== 1'b1) begin bad++; $display("FAIL cont_reenter got erase=%b want 1", erase0); end
    end else begin
      if (busy0 !== 1'b0 || erase0 !== 1'b0) begin
        bad++; $display("FAIL back_idle got busy=%b erase=%b want 0 0", busy0, erase0);
      end
    end
  endtask

  // Walks one frame of dut1 starting at its first ERASE cycle.
  task automatic walk1(input int e_eff);
    int   s, n;
    exp_t item;
    s = int'(cyc) - 1;
    for (int r = 0; r < 4; r++)
      sb1.push_back('{row: r, data: 16'({tgt1[r][2], tgt1[r][1], tgt1[r][0]})});
    n = 0;
    while (convert1 !== 1'b1 && n < 200) begin n++; tick(); end
    total++;
    if (convert1 !== 1'b1) begin bad++; $display("FAIL convert1_timeout got convert=%b want 1", convert1); end
    n = 0;
    while (convert1 === 1'b1 && n < 64) begin
      total++;
      if (ramp1 !== 4'(n)) begin bad++; $display("FAIL ramp1 step=%0d got %0d want %0d", n, ramp1, n); end
      n++; tick();
    end
    total++;
    if (n !== int'(ramp_len(4))) begin bad++; $display("FAIL convert1_len got %0d want 16", n); end
    for (int r = 0; r < 4; r++) begin
      n = 0;
      while (ov1 !== 1'b1 && n < 8) begin n++; tick(); end
      total++;
      if (ov1 !== 1'b1 || rr1 !== 4'(1 << r)) begin
        bad++; $display("FAIL row1_out r=%0d got valid=%b read_row=%b want 1 %b", r, ov1, rr1, 4'(1 << r));
      end
      total++;
      if (sb1.size() == 0) begin
        bad++; $display("FAIL sb1_empty got no expected row want one queued");
      end else begin
        item = sb1.pop_front();
        if (od1 !== item.data[11:0] || orow1 !== 2'(item.row)) begin
          bad++;
          $display("FAIL row1_data r=%0d got data=%h row=%0d want data=%h row=%0d", r, od1, orow1, item.data[11:0], item.row);
        end
      end
      total++;
      if (fd1 !== (r == 3)) begin bad++; $display("FAIL frame_done1 r=%0d got %b want %b", r, fd1, (r == 3)); end
      if (r == 3) begin
        total++;
        if (int'(cyc) !== s + int'(frame_len(5, e_eff, 4, 4))) begin
          bad++; $display("FAIL latency1 got %0d want %0d", int'(cyc) - s, frame_len(5, e_eff, 4, 4));
        end
      end
      tick();
    end
    total++;
    if (busy1 !== 1'b0) begin bad++; $display("FAIL back_idle1 got busy=%b want 0", busy1); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++;
    if ({erase0, expose0, convert0, oe0, ramp0, rr0, od0, orow0, ov0, busy0, fd0} !== '0) begin
      bad++; $display("FAIL reset_outputs0 got erase=%b busy=%b data=%h want all 0", erase0, busy0, od0);
    end
    total++;
    if ({erase1, expose1, convert1, oe1, ramp1, rr1, od1, orow1, ov1, busy1, fd1} !== '0) begin
      bad++; $display("FAIL reset_outputs1 got erase=%b busy=%b data=%h want all 0", erase1, busy1, od1);
    end
    reset = 1'b0;
    repeat (2) tick();
    total++;
    if (busy0 !== 1'b0 || erase0 !== 1'b0) begin
      bad++; $display("FAIL idle_no_start got busy=%b erase=%b want 0 0", busy0, erase0);
    end
  endtask

  task automatic test_single_frame();
    tgt0 = '{'{8'd0, 8'd255}, '{8'd17, 8'd128}};
    explen0 = 16'd10;
    start0 = 1'b1; tick(); start0 = 1'b0;
    walk0(10, 0, 1'b0);
    repeat (3) tick();
    total++;
    if (busy0 !== 1'b0) begin bad++; $display("FAIL stay_idle got busy=%b want 0", busy0); end
  endtask

  task automatic test_expose_zero();
    tgt0 = '{'{8'd1, 8'd2}, '{8'd254, 8'd99}};
    explen0 = 16'd0;
    start0 = 1'b1; tick(); start0 = 1'b0;
    walk0(1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    tgt0 = '{'{8'd200, 8'd33}, '{8'd64, 8'd7}};
    explen0 = 16'd4;
    start0 = 1'b1; tick(); start0 = 1'b0;
    walk0(4, 7, 1'b0);
  endtask

  // Start held high through the first frame must be ignored outside IDLE.
  task automatic test_cont_mode();
    tgt0 = '{'{8'd10, 8'd20}, '{8'd30, 8'd40}};
    cont0 = 1'b1;
    explen0 = 16'd10;
    start0 = 1'b1; tick();
    explen0 = 16'd20;
    walk0(10, 0, 1'b1);
    start0 = 1'b0;
    cont0 = 1'b0;
    tgt0 = '{'{8'd5, 8'd250}, '{8'd111, 8'd0}};
    walk0(20, 0, 1'b0);
  endtask

  task automatic test_reset_mid_convert();
    int n;
    explen0 = 16'd2;
    start0 = 1'b1; tick(); start0 = 1'b0;
    n = 0;
    while (convert0 !== 1'b1 && n < 50) begin n++; tick(); end
    repeat (20) tick();
    reset = 1'b1;
    #1;
    total++;
    if ({erase0, expose0, convert0, oe0, ramp0, rr0, od0, orow0, ov0, busy0, fd0} !== '0) begin
      bad++;
      $display("FAIL async_reset got convert=%b ramp=%0d data=%h busy=%b want all 0", convert0, ramp0, od0, busy0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (fd0 !== 1'b0 || busy0 !== 1'b0) begin
        bad++; $display("FAIL reset_hold i=%0d got frame_done=%b busy=%b want 0 0", i, fd0, busy0);
      end
    end
    reset = 1'b0;
    sb0.delete();
    repeat (2) tick();
    total++;
    if (busy0 !== 1'b0 || erase0 !== 1'b0 || fd0 !== 1'b0) begin
      bad++; $display("FAIL after_reset got busy=%b erase=%b frame_done=%b want 0 0 0", busy0, erase0, fd0);
    end
  endtask

  task automatic test_large_array();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        tgt1[r][c] = 4'((r * 5 + c * 7) % 16);
    tgt1[0][0] = 4'd0;
    tgt1[3][2] = 4'd15;
    explen1 = 16'd3;
    start1 = 1'b1; tick(); start1 = 1'b0;
    walk1(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    test_reset();
    test_single_frame();
    test_expose_zero();
    test_backpressure();
    test_cont_mode();
    test_reset_mid_convert();
    test_large_array();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
